mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single byte-addressable memory instance between the instruction-fetch requester (I-port) and the load/store requester (D-port).
- Accepts one request at a time and drives the memory's address, data, enable and funct3 inputs from a registered request.
- Captures the memory's combinational read data and returns it with a one-cycle valid pulse.
- Sits between the fetch/memory stages and the memory instance.

Parameters:
- AWIDTH, 32, address width.
- DWIDTH, 32, data width.
- STARVE_LIMIT, 4, consecutive lost arbitrations after which the I-port is forced to win.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- i_req_i  in  1  fetch request; must be held until granted.
- i_addr_i  in  AWIDTH  fetch address; always an LW.
- i_kill_i  in  1  discard the in-flight fetch response (redirect).
- i_gnt_o  out  1  fetch accepted this cycle.
- i_rvalid_o  out  1  fetch data valid (1-cycle pulse).
- i_rdata_o  out  DWIDTH  fetch data.
- d_req_i  in  1  load/store request; must be held until granted.
- d_we_i  in  1  1 = store, 0 = load.
- d_addr_i  in  AWIDTH  data address.
- d_wdata_i  in  DWIDTH  store data.
- d_funct3_i  in  3  access size and sign.
- d_gnt_o  out  1  D request accepted this cycle.
- d_rvalid_o  out  1  load data valid, or store-complete pulse.
- d_rdata_o  out  DWIDTH  load data; 0 for stores.
- mem_addr_o  out  AWIDTH  to memory addr_i.
- mem_wdata_o  out  DWIDTH  to memory data_i.
- mem_read_en_o  out  1  to memory read_en_i.
- mem_write_en_o  out  1  to memory write_en_i.
- mem_funct3_o  out  3  to memory funct3_i.
- mem_rdata_i  in  DWIDTH  from memory data_o (combinational read).

Behaviour:
- FSM states: IDLE, ACCESS.
- Reset (rst = 0, asynchronous):
  - state = IDLE; starve_cnt = 0; owner = D.
  - All gnt_o, rvalid_o, mem_*_en_o = 0; rdata_o = 0; request register = 0.
- IDLE:
  - gnt_o is combinational from the req inputs; at most one gnt_o is high.
  - Arbitration: D wins if d_req_i and starve_cnt < STARVE_LIMIT; otherwise I wins if i_req_i; otherwise D wins if d_req_i.
  - On a grant, the edge latches addr, wdata, we and funct3 into the request register, latches owner, and moves to ACCESS.
  - An I grant latches funct3 = FUNCT3_LW and we = 0.
  - No request: stay in IDLE, memory enables 0.
- ACCESS (exactly one cycle):
  - mem_addr_o, mem_wdata_o and mem_funct3_o come from the request register.
  - mem_read_en_o = !we; mem_write_en_o = we. The store commits at the end of ACCESS.
  - At the edge ending ACCESS: owner's rvalid_o <= 1; owner's rdata_o <= mem_rdata_i (load) or 0 (store); state -> IDLE.
- rvalid_o is high for exactly one cycle, in the IDLE cycle following ACCESS. A new grant may be issued in that same cycle.
- rdata_o holds its value until the next response for that port.
- Latency: gnt in cycle N, memory access in cycle N+1, rvalid in cycle N+2. Peak throughput is one access per 2 cycles.
- Outside ACCESS, mem_read_en_o = mem_write_en_o = 0 and the mem_* data outputs hold the request register.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on each IDLE cycle where i_req_i = 1 and D is granted.
  - Clears to 0 on any I grant, or on an IDLE cycle with i_req_i = 0.
- Kill:
  - i_kill_i high in the ACCESS cycle of an I-owned access, or in the same cycle as i_gnt_o, suppresses that i_rvalid_o. i_rdata_o is still updated.
  - i_kill_i has no effect on D accesses.
- Simultaneous requests: D has priority, subject to the starvation rule.
- Request inputs may change freely after gnt.
- Reset asserted mid-ACCESS: the pending access is abandoned, no rvalid is produced, and memory enables drop immediately.

Decomposition:
- Shared package holds:
  - the FUNCT3_* load/store constants already used by memory;
  - an arb_state_e enum {IDLE, ACCESS};
  - an owner_e enum {OWNER_I, OWNER_D};
  - a mem_req_t struct {addr, wdata, we, funct3}.
- Optional sub-module arb_starve_counter (saturating counter, clear/increment inputs). The rest stays flat.

Test Plan:
- Reset then single I request, addr 0x01000000, memory word 0x00000013 → i_gnt_o in cycle 0, mem_read_en_o in cycle 1, i_rvalid_o = 1 with i_rdata_o = 0x00000013 in cycle 2, no d_rvalid_o.
- D store SW 0xCAFEBABE to 0x01000010, then D load LW from the same address → mem_write_en_o high for one cycle, d_rvalid_o with d_rdata_o = 0; load returns 0xCAFEBABE two cycles after its grant.
- I and D requesting simultaneously, STARVE_LIMIT = 4, D requesting continuously → first four grants go to D, fifth grant goes to I, starve_cnt = 0 afterwards.
- LB from a byte holding 0x80 with d_funct3_i = FUNCT3_LB → mem_funct3_o = FUNCT3_LB in ACCESS, d_rdata_o = 0xFFFFFF80.
- I request granted, i_kill_i pulsed during ACCESS → i_rvalid_o stays 0; the next I request returns data normally.
- rst driven low in the middle of a D-store ACCESS → mem_write_en_o = 0 immediately, all outputs at reset values, memory contents unchanged.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the I/D memory port arbiter.
// The FUNCT3 encodings match the ones the memory instance decodes.
package mem_port_arbiter_pkg;

  localparam int MEM_AWIDTH = 32;
  localparam int MEM_DWIDTH = 32;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  typedef enum logic {IDLE, ACCESS} arb_state_e;
  typedef enum logic {OWNER_I, OWNER_D} owner_e;

  typedef struct packed {
    logic [MEM_AWIDTH-1:0] addr;
    logic [MEM_DWIDTH-1:0] wdata;
    logic                  we;
    logic [2:0]            funct3;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch port, load/store port and memory-side signals of the arbiter.
// slave = arbiter side, master = requesters plus memory instance.
interface mem_port_arbiter_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic              i_req_i;
  logic [AWIDTH-1:0] i_addr_i;
  logic              i_kill_i;
  logic              i_gnt_o;
  logic              i_rvalid_o;
  logic [DWIDTH-1:0] i_rdata_o;

  logic              d_req_i;
  logic              d_we_i;
  logic [AWIDTH-1:0] d_addr_i;
  logic [DWIDTH-1:0] d_wdata_i;
  logic [2:0]        d_funct3_i;
  logic              d_gnt_o;
  logic              d_rvalid_o;
  logic [DWIDTH-1:0] d_rdata_o;

  logic [AWIDTH-1:0] mem_addr_o;
  logic [DWIDTH-1:0] mem_wdata_o;
  logic              mem_read_en_o;
  logic              mem_write_en_o;
  logic [2:0]        mem_funct3_o;
  logic [DWIDTH-1:0] mem_rdata_i;

  modport slave (
    input  i_req_i, i_addr_i, i_kill_i,
    input  d_req_i, d_we_i, d_addr_i, d_wdata_i, d_funct3_i,
    input  mem_rdata_i,
    output i_gnt_o, i_rvalid_o, i_rdata_o,
    output d_gnt_o, d_rvalid_o, d_rdata_o,
    output mem_addr_o, mem_wdata_o, mem_read_en_o, mem_write_en_o, mem_funct3_o
  );

  modport master (
    output i_req_i, i_addr_i, i_kill_i,
    output d_req_i, d_we_i, d_addr_i, d_wdata_i, d_funct3_i,
    output mem_rdata_i,
    input  i_gnt_o, i_rvalid_o, i_rdata_o,
    input  d_gnt_o, d_rvalid_o, d_rdata_o,
    input  mem_addr_o, mem_wdata_o, mem_read_en_o, mem_write_en_o, mem_funct3_o
  );
endinterface

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating count of consecutive arbitrations the fetch port has lost.
// starved is high once the count reaches LIMIT.
module mem_port_arbiter_starve_counter #(
  parameter int LIMIT = 4,
  localparam int CW   = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic starved
);

  logic [CW-1:0] cnt;

  assign starved = (cnt >= CW'(LIMIT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !starved) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory instance between instruction fetch (I) and load/store (D).
// One registered access at a time; response pulses two cycles after the grant.
//
//   state  | meaning
//   IDLE   | arbitrating; may grant one port, may be showing the last rvalid
//   ACCESS | memory driven from the request register for exactly one cycle
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AWIDTH       = MEM_AWIDTH,
  parameter int DWIDTH       = MEM_DWIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  mem_port_arbiter_if.slave bus
);

  arb_state_e        state_q, state_d;
  owner_e            owner_q;
  mem_req_t          req_q;
  logic              kill_q;
  logic              i_gnt, d_gnt, starved;
  logic              i_rvalid_q, d_rvalid_q;
  logic [DWIDTH-1:0] i_rdata_q, d_rdata_q;

  mem_port_arbiter_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk     (clk),
    .rst     (rst),
    .clr     ((state_q == IDLE) && (i_gnt || !bus.i_req_i)),
    .inc     ((state_q == IDLE) && bus.i_req_i && d_gnt),
    .starved (starved)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Grants are gated by rst so nothing is accepted while reset is held.
  always_comb begin
    state_d = state_q;
    i_gnt   = 1'b0;
    d_gnt   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rst) begin
          if (bus.d_req_i && (!starved || !bus.i_req_i)) d_gnt = 1'b1;
          else if (bus.i_req_i)                          i_gnt = 1'b1;
        end
        if (i_gnt || d_gnt) state_d = ACCESS;
      end
      ACCESS:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q      <= '0;
      owner_q    <= OWNER_D;
      kill_q     <= 1'b0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      if (i_gnt) begin
        req_q.addr   <= bus.i_addr_i;
        req_q.wdata  <= '0;
        req_q.we     <= 1'b0;
        req_q.funct3 <= FUNCT3_LW;
        owner_q      <= OWNER_I;
        kill_q       <= bus.i_kill_i;
      end else if (d_gnt) begin
        req_q.addr   <= bus.d_addr_i;
        req_q.wdata  <= bus.d_wdata_i;
        req_q.we     <= bus.d_we_i;
        req_q.funct3 <= bus.d_funct3_i;
        owner_q      <= OWNER_D;
        kill_q       <= 1'b0;
      end
      // A kill seen at grant or during the access drops only the valid pulse.
      if (state_q == ACCESS) begin
        if (owner_q == OWNER_I) begin
          i_rvalid_q <= !(kill_q || bus.i_kill_i);
          i_rdata_q  <= bus.mem_rdata_i;
        end else begin
          d_rvalid_q <= 1'b1;
          d_rdata_q  <= req_q.we ? '0 : bus.mem_rdata_i;
        end
      end
    end
  end

  assign bus.i_gnt_o        = i_gnt;
  assign bus.d_gnt_o        = d_gnt;
  assign bus.i_rvalid_o     = i_rvalid_q;
  assign bus.d_rvalid_o     = d_rvalid_q;
  assign bus.i_rdata_o      = i_rdata_q;
  assign bus.d_rdata_o      = d_rdata_q;
  assign bus.mem_addr_o     = req_q.addr[AWIDTH-1:0];
  assign bus.mem_wdata_o    = req_q.wdata;
  assign bus.mem_funct3_o   = req_q.funct3;
  assign bus.mem_read_en_o  = (state_q == ACCESS) && !req_q.we;
  assign bus.mem_write_en_o = (state_q == ACCESS) && req_q.we;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a cycle-level transaction model
// and a byte-array reference memory, plus directed boundary scenarios.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // memory instance stand-in: combinational read, write on the rising edge
  logic [7:0]  mem [1024];
  logic        bd_we;
  logic [9:0]  bd_addr;
  logic [7:0]  bd_data;
  logic [9:0]  ma;
  logic [31:0] mw;

  assign ma = bus.mem_addr_o[9:0];
  assign mw = {mem[ma + 10'd3], mem[ma + 10'd2], mem[ma + 10'd1], mem[ma]};

  always_comb begin
    bus.mem_rdata_i = mw;
    case (bus.mem_funct3_o)
      FUNCT3_LB:  bus.mem_rdata_i = {{24{mw[7]}}, mw[7:0]};
      FUNCT3_LH:  bus.mem_rdata_i = {{16{mw[15]}}, mw[15:0]};
      FUNCT3_LBU: bus.mem_rdata_i = {24'b0, mw[7:0]};
      FUNCT3_LHU: bus.mem_rdata_i = {16'b0, mw[15:0]};
      default:    bus.mem_rdata_i = mw;
    endcase
  end

  always @(posedge clk) begin
    if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end else if (bus.mem_write_en_o) begin
      mem[ma] <= bus.mem_wdata_o[7:0];
      if (bus.mem_funct3_o[1:0] != 2'b00) mem[ma + 10'd1] <= bus.mem_wdata_o[15:8];
      if (bus.mem_funct3_o[1:0] == 2'b10) begin
        mem[ma + 10'd2] <= bus.mem_wdata_o[23:16];
        mem[ma + 10'd3] <= bus.mem_wdata_o[31:24];
      end
    end
  end

  // reference model state
  logic [7:0]  ref_mem [1024];
  bit          m_access, m_own_d, m_we, m_kill;
  logic [31:0] m_addr, m_wdata;
  logic [2:0]  m_f3;
  bit          m_rv_i, m_rv_d;
  logic [31:0] m_rd_i, m_rd_d;
  int          m_starve;
  bit          i_pend, d_pend;
  bit          obs_ig, obs_dg;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
    int    base, nbytes;
    longint v;
    base   = int'(a[9:0]);
    nbytes = 1 << f3[1:0];
    v = 0;
    for (int k = 0; k < nbytes; k++) v += longint'(ref_mem[(base + k) % 1024]) << (8 * k);
    if (!f3[2] && nbytes < 4 && v >= (longint'(1) << (8 * nbytes - 1)))
      v -= (longint'(1) << (8 * nbytes));
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
    int base, nbytes;
    base   = int'(a[9:0]);
    nbytes = 1 << f3[1:0];
    for (int k = 0; k < nbytes; k++) ref_mem[(base + k) % 1024] = 8'(d >> (8 * k));
  endtask

  function automatic logic [31:0] bench_word(input int idx);
    return {mem[idx + 3], mem[idx + 2], mem[idx + 1], mem[idx]};
  endfunction

  // One clock cycle: predict, check mid-cycle, advance the model, move to next negedge.
  task automatic step();
    bit ig, dg, nrv_i, nrv_d;
    ig = 0; dg = 0; nrv_i = 0; nrv_d = 0;
    if (!m_access) begin
      if (bus.d_req_i && (m_starve < LIMIT || !bus.i_req_i)) dg = 1;
      else if (bus.i_req_i)                                  ig = 1;
    end
    #1;
    obs_ig = bus.i_gnt_o;
    obs_dg = bus.d_gnt_o;
    check_eq("i_gnt",    32'(bus.i_gnt_o),        32'(ig));
    check_eq("d_gnt",    32'(bus.d_gnt_o),        32'(dg));
    check_eq("i_rvalid", 32'(bus.i_rvalid_o),     32'(m_rv_i));
    check_eq("d_rvalid", 32'(bus.d_rvalid_o),     32'(m_rv_d));
    check_eq("i_rdata",  bus.i_rdata_o,           m_rd_i);
    check_eq("d_rdata",  bus.d_rdata_o,           m_rd_d);
    check_eq("rd_en",    32'(bus.mem_read_en_o),  32'(m_access && !m_we));
    check_eq("wr_en",    32'(bus.mem_write_en_o), 32'(m_access && m_we));
    if (m_access) begin
      check_eq("mem_addr",   bus.mem_addr_o,        m_addr);
      check_eq("mem_funct3", 32'(bus.mem_funct3_o), 32'(m_f3));
      if (m_we) check_eq("mem_wdata", bus.mem_wdata_o, m_wdata);
    end
    if (m_access) begin
      if (m_own_d) begin
        nrv_d = 1;
        if (m_we) begin
          m_rd_d = '0;
          ref_store(m_addr, m_f3, m_wdata);
        end else begin
          m_rd_d = ref_load(m_addr, m_f3);
        end
      end else begin
        nrv_i  = !(m_kill || bus.i_kill_i);
        m_rd_i = ref_load(m_addr, FUNCT3_LW);
      end
      m_access = 0;
    end else begin
      if (ig || !bus.i_req_i)        m_starve = 0;
      else if (dg && m_starve < LIMIT) m_starve++;
      if (ig) begin
        m_access = 1; m_own_d = 0; m_we = 0; m_f3 = FUNCT3_LW;
        m_addr = bus.i_addr_i; m_kill = bus.i_kill_i; i_pend = 0;
      end
      if (dg) begin
        m_access = 1; m_own_d = 1; m_we = bus.d_we_i; m_f3 = bus.d_funct3_i;
        m_addr = bus.d_addr_i; m_wdata = bus.d_wdata_i; d_pend = 0;
      end
    end
    m_rv_i = nrv_i;
    m_rv_d = nrv_d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_access = 0; m_rv_i = 0; m_rv_d = 0; m_rd_i = '0; m_rd_d = '0; m_starve = 0;
    m_we = 0; m_own_d = 1; m_kill = 0; m_addr = '0; m_wdata = '0; m_f3 = '0;
  endtask

  task automatic set_d(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    bus.d_req_i = 1'b1; bus.d_we_i = we; bus.d_funct3_i = f3; bus.d_addr_i = a; bus.d_wdata_i = d;
  endtask

  task automatic drive_random();
    int sz;
    if (!i_pend) begin
      if ($urandom_range(2) == 0) begin
        i_pend = 1;
        bus.i_addr_i = 32'h0100_0000 | ($urandom_range(255) << 2);
      end else begin
        bus.i_addr_i = $urandom;
      end
    end
    if (!d_pend) begin
      sz = $urandom_range(2);
      bus.d_we_i     = 1'($urandom_range(1));
      bus.d_funct3_i = 3'(sz);
      if (!bus.d_we_i && sz < 2 && $urandom_range(1) == 1) bus.d_funct3_i[2] = 1'b1;
      bus.d_addr_i   = 32'h0100_0000 | ($urandom_range(1023) & ~((1 << sz) - 1));
      bus.d_wdata_i  = $urandom;
      d_pend = ($urandom_range(2) == 0);
    end
    bus.i_req_i  = i_pend;
    bus.d_req_i  = d_pend;
    bus.i_kill_i = ($urandom_range(7) == 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  b;
    logic [31:0] old_word;
    int          nd;
    bit          i_won;

    bus.i_req_i = 0; bus.i_addr_i = '0; bus.i_kill_i = 0;
    bus.d_req_i = 0; bus.d_we_i = 0; bus.d_addr_i = '0; bus.d_wdata_i = '0; bus.d_funct3_i = '0;
    bd_we = 0; bd_addr = '0; bd_data = '0;
    i_pend = 0; d_pend = 0;
    model_reset();

    @(negedge clk);
    for (int i = 0; i < 1024; i++) begin
      b = 8'($urandom);
      if (i == 0)                 b = 8'h13;
      else if (i >= 1 && i <= 3)  b = 8'h00;
      else if (i == 32)           b = 8'h80;
      ref_mem[i] = b;
      bd_we = 1; bd_addr = 10'(i); bd_data = b;
      @(negedge clk);
    end
    bd_we = 0;

    #1;
    check_eq("rst_i_gnt",    32'(bus.i_gnt_o),        0);
    check_eq("rst_d_gnt",    32'(bus.d_gnt_o),        0);
    check_eq("rst_i_rvalid", 32'(bus.i_rvalid_o),     0);
    check_eq("rst_d_rvalid", 32'(bus.d_rvalid_o),     0);
    check_eq("rst_i_rdata",  bus.i_rdata_o,           0);
    check_eq("rst_d_rdata",  bus.d_rdata_o,           0);
    check_eq("rst_rd_en",    32'(bus.mem_read_en_o),  0);
    check_eq("rst_wr_en",    32'(bus.mem_write_en_o), 0);
    check_eq("rst_mem_addr", bus.mem_addr_o,          0);
    @(negedge clk);
    rst = 1'b1;
    step();

    // single fetch
    bus.i_req_i = 1; bus.i_addr_i = 32'h0100_0000;
    step();
    bus.i_req_i = 0;
    step();
    step();
    check_eq("fetch_data", bus.i_rdata_o, 32'h0000_0013);

    // store then load back
    set_d(1, FUNCT3_SW, 32'h0100_0010, 32'hCAFE_BABE);
    step();
    bus.d_req_i = 0;
    step();
    step();
    check_eq("store_rdata", bus.d_rdata_o, 0);
    set_d(0, FUNCT3_LW, 32'h0100_0010, 32'h0);
    step();
    bus.d_req_i = 0;
    step();
    step();
    check_eq("load_cafe", bus.d_rdata_o, 32'hCAFE_BABE);

    // starvation: both request continuously
    bus.i_req_i = 1; bus.i_addr_i = 32'h0100_0040;
    set_d(0, FUNCT3_LW, 32'h0100_0100, 32'h0);
    nd = 0; i_won = 0;
    for (int k = 0; k < 20 && !i_won; k++) begin
      step();
      if (obs_dg) begin
        nd++;
        bus.d_addr_i = 32'h0100_0000 | ($urandom_range(255) << 2);
      end
      if (obs_ig) begin
        i_won = 1;
        bus.i_req_i = 0;
      end
    end
    check_eq("starve_d_grants", 32'(nd), 4);
    check_eq("starve_i_won",    32'(i_won), 1);
    check_eq("starve_cnt_clr",  32'(dut.u_starve.cnt), 0);
    bus.d_req_i = 0;
    step();
    step();

    // signed byte load
    set_d(0, FUNCT3_LB, 32'h0100_0020, 32'h0);
    step();
    bus.d_req_i = 0;
    step();
    step();
    check_eq("lb_data", bus.d_rdata_o, 32'hFFFF_FF80);

    // kill during ACCESS, then a normal fetch
    bus.i_req_i = 1; bus.i_addr_i = 32'h0100_0004;
    step();
    bus.i_req_i = 0; bus.i_kill_i = 1;
    step();
    bus.i_kill_i = 0;
    step();
    bus.i_req_i = 1; bus.i_addr_i = 32'h0100_0008;
    step();
    bus.i_req_i = 0;
    step();
    step();

    // reset asserted in the middle of a store ACCESS
    old_word = ref_load(32'h0100_0030, FUNCT3_LW);
    set_d(1, FUNCT3_SW, 32'h0100_0030, 32'hDEAD_BEEF);
    step();
    #1;
    check_eq("mid_wr_en_before", 32'(bus.mem_write_en_o), 1);
    rst = 1'b0;
    #1;
    check_eq("mid_wr_en",    32'(bus.mem_write_en_o), 0);
    check_eq("mid_rd_en",    32'(bus.mem_read_en_o),  0);
    check_eq("mid_d_gnt",    32'(bus.d_gnt_o),        0);
    check_eq("mid_d_rvalid", 32'(bus.d_rvalid_o),     0);
    check_eq("mid_i_rdata",  bus.i_rdata_o,           0);
    check_eq("mid_d_rdata",  bus.d_rdata_o,           0);
    check_eq("mid_mem_addr", bus.mem_addr_o,          0);
    @(posedge clk);
    #1;
    check_eq("mid_wr_en_edge", 32'(bus.mem_write_en_o), 0);
    check_eq("mid_d_rvalid2",  32'(bus.d_rvalid_o),     0);
    @(negedge clk);
    check_eq("mid_mem_kept", bench_word(48), old_word);
    bus.d_req_i = 0;
    rst = 1'b1;
    model_reset();
    step();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      drive_random();
      step();
    end
    bus.i_req_i = 0; bus.d_req_i = 0; bus.i_kill_i = 0;
    step();
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
